// File: rtl/key_debounce_array.sv
// key_debounce_array: per-key sync/debounce with press, release, long-press and optional auto-repeat (KEY_REPEAT_EN) pulses
module key_debounce_array #(
    parameter int   NUM_KEYS   = 4,
    parameter int   CNT_MAX    = 1_000_000,
    parameter int   LONG_MAX   = 50_000_000,
    parameter int   REPEAT_MAX = 10_000_000,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] press_flag,
    output logic [NUM_KEYS-1:0] release_flag,
    output logic [NUM_KEYS-1:0] long_flag,
    output logic [NUM_KEYS-1:0] repeat_flag
);
    localparam int CW = CNT_MAX > 1 ? $clog2(CNT_MAX) : 1;
    localparam int HW = $clog2(LONG_MAX + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
    localparam logic [HW-1:0] LONG_V = HW'(LONG_MAX);
    localparam logic [HW-1:0] HOLD_SAT = '1;
    logic [NUM_KEYS-1:0] sync1_q, sync2_q, key_state_q, key_state_d;
    logic [NUM_KEYS-1:0] press_q, press_d, release_q, release_d, long_q, long_d;
    logic [NUM_KEYS-1:0] flip, held;
    logic [CW-1:0] cnt_q [NUM_KEYS];
    logic [CW-1:0] cnt_d [NUM_KEYS];
    logic [HW-1:0] hold_q [NUM_KEYS];
    logic [HW-1:0] hold_d [NUM_KEYS];
    always_comb begin
        key_state_d = key_state_q;
        press_d = '0;
        release_d = '0;
        long_d = '0;
        flip = '0;
        held = '0;
        cnt_d = cnt_q;
        hold_d = hold_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            flip[k] = sync2_q[k] != key_state_q[k] && cnt_q[k] == CNT_LAST;
            key_state_d[k] = flip[k] ? sync2_q[k] : key_state_q[k];
            cnt_d[k] = (sync2_q[k] != key_state_q[k] && !flip[k]) ? cnt_q[k] + CW'(1) : '0;
            held[k] = key_state_d[k] != IDLE_LEVEL;
            press_d[k] = flip[k] && held[k];
            release_d[k] = flip[k] && !held[k];
            hold_d[k] = !held[k] ? '0 : flip[k] ? HW'(1) : hold_q[k] == HOLD_SAT ? hold_q[k] : hold_q[k] + HW'(1);
            long_d[k] = held[k] && hold_q[k] == LONG_V;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= {NUM_KEYS{IDLE_LEVEL}};
            sync2_q <= {NUM_KEYS{IDLE_LEVEL}};
            key_state_q <= {NUM_KEYS{IDLE_LEVEL}};
            press_q <= '0;
            release_q <= '0;
            long_q <= '0;
            cnt_q <= '{default: '0};
            hold_q <= '{default: '0};
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            key_state_q <= key_state_d;
            press_q <= press_d;
            release_q <= release_d;
            long_q <= long_d;
            cnt_q <= cnt_d;
            hold_q <= hold_d;
        end
    end
    assign key_state = key_state_q;
    assign press_flag = press_q;
    assign release_flag = release_q;
    assign long_flag = long_q;
`ifdef KEY_REPEAT_EN
    localparam int RW = REPEAT_MAX > 1 ? $clog2(REPEAT_MAX) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_MAX - 1);
    logic [NUM_KEYS-1:0] repeat_q, repeat_d;
    logic [RW-1:0] rep_q [NUM_KEYS];
    logic [RW-1:0] rep_d [NUM_KEYS];
    // Timer runs only once the hold count has passed LONG_MAX, i.e. from the long_flag cycle on
    always_comb begin
        repeat_d = '0;
        rep_d = rep_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            rep_d[k] = (held[k] && hold_q[k] > LONG_V) ? (rep_q[k] == REP_LAST ? '0 : rep_q[k] + RW'(1)) : '0;
            repeat_d[k] = held[k] && hold_q[k] > LONG_V && rep_q[k] == REP_LAST;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_q <= '0;
            rep_q <= '{default: '0};
        end else begin
            repeat_q <= repeat_d;
            rep_q <= rep_d;
        end
    end
    assign repeat_flag = repeat_q;
`else
    assign repeat_flag = '0;
`endif
endmodule
